// File: rtl/mem_access_if.sv
// Memory bus between the memory-access stage (master) and the memory
// system (slave). Requests are held until the slave raises bus_ready.
interface mem_access_if;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_wdata;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_addr, bus_byte_en, bus_wdata, bus_read, bus_write,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_addr, bus_byte_en, bus_wdata, bus_read, bus_write,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Passes execute results straight through,
// runs one held bus transaction per aligned load/store (stalling upstream
// while it is outstanding), and flags misaligned accesses as one-cycle
// exception pulses. Op encoding 2'd3 and size encoding 2'd3 fall back to
// pass-through and word behaviour respectively.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_access_op,
  input  logic [1:0]  mem_access_sz,
  input  logic [31:0] mem_addr,
  input  logic [31:0] data_i,
  input  logic [4:0]  reg_addr_i,
  input  logic        flag_unsigned,
  output logic        stall,
  mem_access_if.master bus,
  output logic [31:0] data_o,
  output logic [4:0]  reg_addr_o,
  output logic        exc_load,
  output logic        exc_store,
  output logic [31:0] exc_badvaddr
);

  localparam logic [1:0] ACCESS_OP_D2R  = 2'd0;
  localparam logic [1:0] ACCESS_OP_M2R  = 2'd1;
  localparam logic [1:0] ACCESS_OP_R2M  = 2'd2;
  localparam logic [1:0] ACCESS_SZ_BYTE = 2'd0;
  localparam logic [1:0] ACCESS_SZ_HALF = 2'd1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  state_t      state_r, state_nxt;
  logic [1:0]  lo_r, lo_nxt;
  logic [1:0]  sz_r, sz_nxt;
  logic [4:0]  reg_r, reg_nxt;
  logic        uns_r, uns_nxt;
  logic [31:0] bus_addr_r, bus_addr_nxt;
  logic [3:0]  bus_be_r, bus_be_nxt;
  logic [31:0] bus_wdata_r, bus_wdata_nxt;
  logic        bus_read_r, bus_read_nxt;
  logic        bus_write_r, bus_write_nxt;
  logic [31:0] data_r, data_nxt;
  logic [4:0]  reg_o_r, reg_o_nxt;
  logic        exc_load_r, exc_load_nxt;
  logic        exc_store_r, exc_store_nxt;
  logic [31:0] badvaddr_r, badvaddr_nxt;
  logic        stall_s;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic r;
    case (sz)
      ACCESS_SZ_BYTE: r = 1'b0;
      ACCESS_SZ_HALF: r = lo[0];
      default:        r = (lo != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] r;
    case (sz)
      ACCESS_SZ_BYTE: r = 4'b0001 << lo;
      ACCESS_SZ_HALF: r = lo[1] ? 4'b1100 : 4'b0011;
      default:        r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      ACCESS_SZ_BYTE: r = {4{d[7:0]}};
      ACCESS_SZ_HALF: r = {2{d[15:0]}};
      default:        r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] lo,
                                               input logic uns, input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rd >> {lo, 3'b000};
    case (sz)
      ACCESS_SZ_BYTE: r = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      ACCESS_SZ_HALF: r = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default:        r = rd;
    endcase
    return r;
  endfunction

  // Next-state, stall and next-output computation for the IDLE/REQ machine.
  always_comb begin
    state_nxt     = state_r;
    lo_nxt        = lo_r;
    sz_nxt        = sz_r;
    reg_nxt       = reg_r;
    uns_nxt       = uns_r;
    bus_addr_nxt  = bus_addr_r;
    bus_be_nxt    = bus_be_r;
    bus_wdata_nxt = bus_wdata_r;
    bus_read_nxt  = bus_read_r;
    bus_write_nxt = bus_write_r;
    data_nxt      = data_r;
    reg_o_nxt     = reg_o_r;
    exc_load_nxt  = 1'b0;
    exc_store_nxt = 1'b0;
    badvaddr_nxt  = badvaddr_r;
    stall_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((mem_access_op == ACCESS_OP_M2R) || (mem_access_op == ACCESS_OP_R2M)) begin
          if (is_misaligned(mem_access_sz, mem_addr[1:0])) begin
            exc_load_nxt  = (mem_access_op == ACCESS_OP_M2R);
            exc_store_nxt = (mem_access_op == ACCESS_OP_R2M);
            badvaddr_nxt  = mem_addr;
            data_nxt      = 32'h0000_0000;
            reg_o_nxt     = 5'd0;
          end else begin
            stall_s       = 1'b1;
            state_nxt     = ST_REQ;
            lo_nxt        = mem_addr[1:0];
            sz_nxt        = mem_access_sz;
            reg_nxt       = reg_addr_i;
            uns_nxt       = flag_unsigned;
            bus_addr_nxt  = {mem_addr[31:2], 2'b00};
            bus_be_nxt    = lane_enable(mem_access_sz, mem_addr[1:0]);
            bus_wdata_nxt = (mem_access_op == ACCESS_OP_R2M) ?
                            lane_wdata(mem_access_sz, data_i) : 32'h0000_0000;
            bus_read_nxt  = (mem_access_op == ACCESS_OP_M2R);
            bus_write_nxt = (mem_access_op == ACCESS_OP_R2M);
          end
        end else begin
          data_nxt  = data_i;
          reg_o_nxt = reg_addr_i;
        end
      end
      ST_REQ: begin
        if (bus.bus_ready) begin
          state_nxt     = ST_IDLE;
          bus_read_nxt  = 1'b0;
          bus_write_nxt = 1'b0;
          bus_addr_nxt  = 32'h0000_0000;
          bus_be_nxt    = 4'b0000;
          bus_wdata_nxt = 32'h0000_0000;
          if (bus_read_r) begin
            data_nxt  = load_extract(sz_r, lo_r, uns_r, bus.bus_rdata);
            reg_o_nxt = reg_r;
          end else begin
            data_nxt  = 32'h0000_0000;
            reg_o_nxt = 5'd0;
          end
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update; reset discards any pending transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      lo_r        <= 2'b00;
      sz_r        <= 2'b00;
      reg_r       <= 5'd0;
      uns_r       <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_be_r    <= 4'b0000;
      bus_wdata_r <= 32'h0000_0000;
      bus_read_r  <= 1'b0;
      bus_write_r <= 1'b0;
      data_r      <= 32'h0000_0000;
      reg_o_r     <= 5'd0;
      exc_load_r  <= 1'b0;
      exc_store_r <= 1'b0;
      badvaddr_r  <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt;
      lo_r        <= lo_nxt;
      sz_r        <= sz_nxt;
      reg_r       <= reg_nxt;
      uns_r       <= uns_nxt;
      bus_addr_r  <= bus_addr_nxt;
      bus_be_r    <= bus_be_nxt;
      bus_wdata_r <= bus_wdata_nxt;
      bus_read_r  <= bus_read_nxt;
      bus_write_r <= bus_write_nxt;
      data_r      <= data_nxt;
      reg_o_r     <= reg_o_nxt;
      exc_load_r  <= exc_load_nxt;
      exc_store_r <= exc_store_nxt;
      badvaddr_r  <= badvaddr_nxt;
    end
  end

  assign stall           = stall_s;
  assign bus.bus_addr    = bus_addr_r;
  assign bus.bus_byte_en = bus_be_r;
  assign bus.bus_wdata   = bus_wdata_r;
  assign bus.bus_read    = bus_read_r;
  assign bus.bus_write   = bus_write_r;
  assign data_o          = data_r;
  assign reg_addr_o      = reg_o_r;
  assign exc_load        = exc_load_r;
  assign exc_store       = exc_store_r;
  assign exc_badvaddr    = badvaddr_r;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, reset-during-transaction
// sequence, and randomized back-to-back traffic against a reference model.
module tb_mem_access;
  localparam logic [1:0] D2R = 2'd0, M2R = 2'd1, R2M = 2'd2;
  localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_access_op, mem_access_sz;
  logic [31:0] mem_addr, data_i;
  logic [4:0]  reg_addr_i;
  logic        flag_unsigned;
  logic        stall;
  logic [31:0] data_o, exc_badvaddr;
  logic [4:0]  reg_addr_o;
  logic        exc_load, exc_store;
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_access_if bus_if ();

  mem_access dut (
    .clk(clk), .rst(rst), .mem_access_op(mem_access_op), .mem_access_sz(mem_access_sz),
    .mem_addr(mem_addr), .data_i(data_i), .reg_addr_i(reg_addr_i),
    .flag_unsigned(flag_unsigned), .stall(stall), .bus(bus_if.master),
    .data_o(data_o), .reg_addr_o(reg_addr_o), .exc_load(exc_load),
    .exc_store(exc_store), .exc_badvaddr(exc_badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rg;
    logic        uns;
    logic [31:0] rdata;
    int          wait_n;
    logic        exp_bus;
    logic        exp_exc;
    logic [31:0] exp_data;
    logic [4:0]  exp_reg;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] data, input logic [4:0] rg, input logic uns,
                              input logic [31:0] rdata, input int wait_n, input logic exp_bus,
                              input logic exp_exc, input logic [31:0] exp_data,
                              input logic [4:0] exp_reg, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.op = op; v.sz = sz; v.addr = addr; v.data = data; v.rg = rg; v.uns = uns;
    v.rdata = rdata; v.wait_n = wait_n; v.exp_bus = exp_bus; v.exp_exc = exp_exc;
    v.exp_data = exp_data; v.exp_reg = exp_reg; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Reference model: access width in bytes, lane offset, shift/mask/sign arithmetic.
  function automatic vec_t model(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [4:0] rg, input logic uns,
                                 input logic [31:0] rdata, input int wait_n);
    vec_t v;
    int nb, off;
    longint mask, val;
    v = mk(op, sz, addr, data, rg, uns, rdata, wait_n, 1'b0, 1'b0, 32'h0, 5'd0, 4'h0, 32'h0);
    nb = (sz == SB) ? 1 : (sz == SH) ? 2 : 4;
    off = int'(addr % 4);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    if (op == D2R) begin
      v.exp_data = data;
      v.exp_reg = rg;
    end else if ((addr % nb) != 0) begin
      v.exp_exc = 1'b1;
    end else begin
      v.exp_bus = 1'b1;
      v.exp_be = 4'(((1 << nb) - 1) << off);
      if (op == R2M) begin
        val = 0;
        for (int i = 0; i < 4 / nb; i++) val = val | ((longint'(data) & mask) << (8 * nb * i));
        v.exp_wdata = val[31:0];
      end else begin
        val = (longint'(rdata) >> (8 * off)) & mask;
        if (!uns && (((val >> (8 * nb - 1)) & 64'd1) != 0)) val = val - (64'd1 << (8 * nb));
        v.exp_data = val[31:0];
        v.exp_reg = rg;
      end
    end
    return v;
  endfunction

  // Runs one upstream request through the stage; entered and left just after a rising edge.
  task automatic do_op(input vec_t v, input bit scramble, input string tag);
    mem_access_op = v.op; mem_access_sz = v.sz; mem_addr = v.addr;
    data_i = v.data; reg_addr_i = v.rg; flag_unsigned = v.uns;
    bus_if.bus_ready = 1'b0;
    #1;
    chk({tag, " stall_accept"}, 32'(stall), 32'(v.exp_bus));
    chk({tag, " idle_no_req"}, 32'({bus_if.bus_read, bus_if.bus_write}), 32'd0);
    step();
    if (!v.exp_bus) begin
      chk({tag, " data_o"}, data_o, v.exp_data);
      chk({tag, " reg_addr_o"}, 32'(reg_addr_o), 32'(v.exp_reg));
      chk({tag, " no_bus"}, 32'({bus_if.bus_read, bus_if.bus_write}), 32'd0);
      chk({tag, " exc_load"}, 32'(exc_load), 32'(v.exp_exc && v.op == M2R));
      chk({tag, " exc_store"}, 32'(exc_store), 32'(v.exp_exc && v.op == R2M));
      if (v.exp_exc) begin
        chk({tag, " badvaddr"}, exc_badvaddr, v.addr);
        mem_access_op = D2R; data_i = 32'h0; reg_addr_i = 5'd0;
        step();
        chk({tag, " exc_pulse_end"}, 32'({exc_load, exc_store}), 32'd0);
      end
    end else begin
      for (int k = 0; k <= v.wait_n; k++) begin
        bus_if.bus_ready = (k == v.wait_n);
        bus_if.bus_rdata = (k == v.wait_n) ? v.rdata : $urandom;
        if (scramble) begin
          mem_addr = $urandom; data_i = $urandom; mem_access_op = 2'($urandom_range(0, 2));
        end
        #1;
        chk({tag, " stall_req"}, 32'(stall), 32'(k != v.wait_n));
        chk({tag, " bus_read"}, 32'(bus_if.bus_read), 32'(v.op == M2R));
        chk({tag, " bus_write"}, 32'(bus_if.bus_write), 32'(v.op == R2M));
        chk({tag, " bus_addr"}, bus_if.bus_addr, {v.addr[31:2], 2'b00});
        chk({tag, " byte_en"}, 32'(bus_if.bus_byte_en), 32'(v.exp_be));
        chk({tag, " wdata"}, bus_if.bus_wdata, v.exp_wdata);
        step();
      end
      bus_if.bus_ready = 1'b0;
      chk({tag, " req_dropped"}, 32'({bus_if.bus_read, bus_if.bus_write}), 32'd0);
      chk({tag, " data_o"}, data_o, v.exp_data);
      chk({tag, " reg_addr_o"}, 32'(reg_addr_o), 32'(v.exp_reg));
    end
  endtask

  vec_t tbl[14];
  vec_t rv;

  initial begin
    tbl[0]  = mk(D2R, SW, 32'h0, 32'h0000_1234, 5'd5, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0000_1234, 5'd5, 4'h0, 32'h0);
    tbl[1]  = mk(M2R, SB, 32'h0000_1003, 32'h0, 5'd7, 1'b0, 32'h80FF_1122, 3, 1'b1, 1'b0, 32'hFFFF_FF80, 5'd7, 4'b1000, 32'h0);
    tbl[2]  = mk(R2M, SH, 32'h0000_2002, 32'hAAAA_BEEF, 5'd9, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 5'd0, 4'b1100, 32'hBEEF_BEEF);
    tbl[3]  = mk(M2R, SW, 32'h0000_3001, 32'h0, 5'd4, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 5'd0, 4'h0, 32'h0);
    tbl[4]  = mk(M2R, SH, 32'h0000_4002, 32'h0, 5'd3, 1'b1, 32'h8001_0000, 1, 1'b1, 1'b0, 32'h0000_8001, 5'd3, 4'b1100, 32'h0);
    tbl[5]  = mk(M2R, SH, 32'h0000_4002, 32'h0, 5'd3, 1'b0, 32'h8001_0000, 0, 1'b1, 1'b0, 32'hFFFF_8001, 5'd3, 4'b1100, 32'h0);
    tbl[6]  = mk(R2M, SB, 32'h0000_5001, 32'h1234_5678, 5'd2, 1'b0, 32'h0, 2, 1'b1, 1'b0, 32'h0, 5'd0, 4'b0010, 32'h7878_7878);
    tbl[7]  = mk(R2M, SW, 32'h0000_6002, 32'h1111_2222, 5'd1, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 5'd0, 4'h0, 32'h0);
    tbl[8]  = mk(R2M, SH, 32'h0000_6003, 32'h1111_2222, 5'd1, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 5'd0, 4'h0, 32'h0);
    tbl[9]  = mk(M2R, SB, 32'h0000_7002, 32'h0, 5'd10, 1'b1, 32'h11AB_2233, 0, 1'b1, 1'b0, 32'h0000_00AB, 5'd10, 4'b0100, 32'h0);
    tbl[10] = mk(M2R, SW, 32'h0000_8000, 32'h0, 5'd31, 1'b0, 32'hDEAD_BEEF, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 5'd31, 4'b1111, 32'h0);
    tbl[11] = mk(R2M, SW, 32'h0000_9004, 32'hCAFE_F00D, 5'd6, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 5'd0, 4'b1111, 32'hCAFE_F00D);
    tbl[12] = mk(M2R, SB, 32'h0000_A000, 32'h0, 5'd8, 1'b0, 32'h0000_007F, 0, 1'b1, 1'b0, 32'h0000_007F, 5'd8, 4'b0001, 32'h0);
    tbl[13] = mk(M2R, SH, 32'h0000_B000, 32'h0, 5'd12, 1'b0, 32'h1234_ABCD, 0, 1'b1, 1'b0, 32'hFFFF_ABCD, 5'd12, 4'b0011, 32'h0);

    rst = 1'b1; mem_access_op = D2R; mem_access_sz = SW; mem_addr = 32'h0; data_i = 32'h0;
    reg_addr_i = 5'd0; flag_unsigned = 1'b0; bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'h0;
    step(); step();
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset bus_req", 32'({bus_if.bus_read, bus_if.bus_write}), 32'd0);
    chk("reset bus_addr", bus_if.bus_addr, 32'h0);
    chk("reset byte_en_wdata", bus_if.bus_wdata | 32'(bus_if.bus_byte_en), 32'h0);
    chk("reset data_o", data_o, 32'h0);
    chk("reset reg_exc", 32'({reg_addr_o, exc_load, exc_store}), 32'd0);
    chk("reset badvaddr", exc_badvaddr, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) do_op(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Reset in the REQ state with bus_ready high: transaction is discarded.
    mem_access_op = M2R; mem_access_sz = SW; mem_addr = 32'h0000_C000; reg_addr_i = 5'd4;
    step();
    chk("rstreq in_req", 32'(bus_if.bus_read), 32'd1);
    rst = 1'b1; bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h5555_AAAA;
    step();
    rst = 1'b0; bus_if.bus_ready = 1'b0;
    mem_access_op = D2R; data_i = 32'h0; reg_addr_i = 5'd0;
    #1;
    chk("rstreq bus_read", 32'(bus_if.bus_read), 32'd0);
    chk("rstreq data_o", data_o, 32'h0);
    chk("rstreq reg_addr_o", 32'(reg_addr_o), 32'd0);
    chk("rstreq stall_idle", 32'(stall), 32'd0);
    step();
    chk("rstreq no_wb", 32'(reg_addr_o), 32'd0);
    do_op(model(M2R, SW, 32'h0000_C000, 32'h0, 5'd4, 1'b0, 32'h0BAD_F00D, 0), 1'b0, "after_rst");

    // Randomized back-to-back traffic; inputs are disturbed while a request is held.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      rv = model(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), a, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 3));
      do_op(rv, 1'b1, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
